// File: rtl/mem_pkg.sv
// Shared load/store definitions: RISC-V funct3 width codes, responder states
// and the alignment/legality helpers used when a request is accepted.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_H, F3_HU: return ~offset[0];
      F3_W:        return offset == 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

  // Stores only have signed widths; the unsigned codes are load-only.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return funct3 inside {F3_B, F3_H, F3_W};
    else    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering between a 32-bit little-endian memory word and the core:
// extends load data and builds byte enables plus a lane-replicated store word.
module lsu_align
  import mem_pkg::*;
(
  input  logic [31:0] rword_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = rword_i[7:0];
    case (offset_i)
      2'd0: byteSel = rword_i[7:0];
      2'd1: byteSel = rword_i[15:8];
      2'd2: byteSel = rword_i[23:16];
      2'd3: byteSel = rword_i[31:24];
      default: byteSel = rword_i[7:0];
    endcase
    halfSel = offset_i[1] ? rword_i[31:16] : rword_i[15:0];

    ldata_o = '0;
    case (funct3_i)
      F3_B:  ldata_o = {{24{byteSel[7]}}, byteSel};
      F3_H:  ldata_o = {{16{halfSel[15]}}, halfSel};
      F3_W:  ldata_o = rword_i;
      F3_BU: ldata_o = {24'h0, byteSel};
      F3_HU: ldata_o = {16'h0, halfSel};
      default: ldata_o = '0;
    endcase
  end

  // Replicating the data across lanes lets the byte enables alone pick the target.
  always_comb begin
    be_o    = 4'b0000;
    wword_o = '0;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << offset_i;
        wword_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
      end
      F3_W: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wword_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time,
// answered after a fixed programmable latency from a byte-addressed RAM.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 17,
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          LATENCY    = 2,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW    = ADDR_WIDTH;
  localparam int WORDS = 2 ** (AW - 2);

  logic [31:0] mem [WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [AW-1:0] off_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q, rdata_d;
  logic        rspErr_q, rspErr_d;

  logic [31:0] reqOff;
  logic        reqInRange, reqErr, accept, commit, ramWe;
  logic        useReq, cmdWe, cmdErr;
  logic [2:0]  cmdF3;
  logic [AW-1:0] cmdOff;
  logic [31:0] cmdWdata, ramWord, ldata, wword;
  logic [3:0]  be;

  assign reqOff     = req_addr - BASE_ADDR;
  assign reqInRange = (req_addr >= BASE_ADDR) && ((reqOff >> AW) == 32'd0);
  assign reqErr     = !reqInRange || !is_legal(req_we, req_funct3)
                      || !is_aligned(req_funct3, reqOff[1:0]);
  assign accept     = (state_q == IDLE) && ready_q && req_valid;

  // With LATENCY==1 the commit happens on the accept edge, before the fields are latched.
  assign useReq   = (state_q == IDLE);
  assign cmdWe    = useReq ? req_we : we_q;
  assign cmdF3    = useReq ? req_funct3 : f3_q;
  assign cmdOff   = useReq ? reqOff[AW-1:0] : off_q;
  assign cmdWdata = useReq ? req_wdata : wdata_q;
  assign cmdErr   = useReq ? reqErr : err_q;
  assign ramWord  = mem[cmdOff[AW-1:2]];
  assign ramWe    = commit && cmdWe && !cmdErr;

  lsu_align uAlign (
    .rword_i  (ramWord),
    .offset_i (cmdOff[1:0]),
    .funct3_i (cmdF3),
    .wdata_i  (cmdWdata),
    .ldata_o  (ldata),
    .be_o     (be),
    .wword_o  (wword)
  );

  assign req_ready = ready_q && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rspErr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d  = rdata_q;
    rspErr_d = rspErr_q;
    if (commit) begin
      rdata_d  = (cmdWe || cmdErr) ? 32'h0 : ldata;
      rspErr_d = cmdErr;
    end else if ((state_q == RESP) && rsp_ready) begin
      rdata_d  = 32'h0;
      rspErr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rspErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= 1'b1;
      rdata_q  <= rdata_d;
      rspErr_q <= rspErr_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        off_q   <= reqOff[AW-1:0];
        wdata_q <= req_wdata;
        err_q   <= reqErr;
      end
    end
  end

  // RAM contents survive reset; only lanes selected by the byte enables change.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[cmdOff[AW-1:2]][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY=2: widths, extension,
// error cases, response back-pressure and reset in the middle of a request.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWe = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [2:0]  reqFunct3 = '0;
  logic [31:0] reqWdata = '0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [31:0] rspRdata;
  logic        rspErr;

  int vectors = 0;
  int miscompares = 0;

  data_mem_responder #(
    .ADDR_WIDTH (17),
    .BASE_ADDR  (32'h0001_0000),
    .LATENCY    (LAT),
    .INIT_FILE  ("")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_we     (reqWe),
    .req_addr   (reqAddr),
    .req_funct3 (reqFunct3),
    .req_wdata  (reqWdata),
    .rsp_valid  (rspValid),
    .rsp_ready  (rspReady),
    .rsp_rdata  (rspRdata),
    .rsp_err    (rspErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request from IDLE (called #1 after a rising edge) and retires it.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [2:0] f3, input logic [31:0] wdata,
                               input logic earlyRdy, input logic [31:0] expData,
                               input logic expErr);
    int cycles;
    checkOutput({tag, "/req_ready"}, 32'(reqReady), 32'd1);
    reqValid  = 1'b1;
    reqWe     = we;
    reqAddr   = addr;
    reqFunct3 = f3;
    reqWdata  = wdata;
    rspReady  = earlyRdy;
    @(posedge clk); #1;
    reqValid = 1'b0;
    cycles = 1;
    while (!rspValid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "/latency"}, 32'(cycles), 32'(LAT));
    if (rspValid) begin
      checkOutput({tag, "/rdata"}, rspRdata, expData);
      checkOutput({tag, "/err"}, 32'(rspErr), 32'(expErr));
      checkOutput({tag, "/busy"}, 32'(reqReady), 32'd0);
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    checkOutput({tag, "/retired"}, 32'(rspValid), 32'd0);
  endtask

  initial begin
    #1;
    checkOutput("rst/req_ready", 32'(reqReady), 32'd0);
    checkOutput("rst/rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst/rdata", rspRdata, 32'h0);
    checkOutput("rst/err", 32'(rspErr), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("sw",   1'b1, 32'h0001_0000, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw",   1'b0, 32'h0001_0000, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    applyStimulus("lb",   1'b0, 32'h0001_0003, 3'b000, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0);
    applyStimulus("lbu",  1'b0, 32'h0001_0003, 3'b100, 32'h0, 1'b0, 32'h000000DE, 1'b0);
    applyStimulus("lh",   1'b0, 32'h0001_0002, 3'b001, 32'h0, 1'b0, 32'hFFFFDEAD, 1'b0);
    applyStimulus("lhu",  1'b0, 32'h0001_0000, 3'b101, 32'h0, 1'b0, 32'h0000BEEF, 1'b0);
    applyStimulus("sb",   1'b1, 32'h0001_0001, 3'b000, 32'hAAAAAA12, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw_sb", 1'b0, 32'h0001_0000, 3'b010, 32'h0, 1'b0, 32'hDEAD12EF, 1'b0);

    applyStimulus("lw_mis",  1'b0, 32'h0001_0002, 3'b010, 32'h0, 1'b0, 32'h0, 1'b1);
    applyStimulus("sh_mis",  1'b1, 32'h0001_0001, 3'b001, 32'h00005555, 1'b0, 32'h0, 1'b1);
    applyStimulus("lw_low",  1'b0, 32'h0000_FFFC, 3'b010, 32'h0, 1'b0, 32'h0, 1'b1);
    applyStimulus("ld_f3_3", 1'b0, 32'h0001_0000, 3'b011, 32'h0, 1'b0, 32'h0, 1'b1);
    applyStimulus("sw_f3_4", 1'b1, 32'h0001_0000, 3'b100, 32'h11223344, 1'b0, 32'h0, 1'b1);
    applyStimulus("lw_high", 1'b0, 32'h0003_0000, 3'b010, 32'h0, 1'b0, 32'h0, 1'b1);
    applyStimulus("lw_kept", 1'b0, 32'h0001_0000, 3'b010, 32'h0, 1'b0, 32'hDEAD12EF, 1'b0);

    applyStimulus("sw_top", 1'b1, 32'h0002_FFFC, 3'b010, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw_top", 1'b0, 32'h0002_FFFC, 3'b010, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
    applyStimulus("sh_hi",  1'b1, 32'h0002_FFFE, 3'b001, 32'h0000BEAD, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw_hi",  1'b0, 32'h0002_FFFC, 3'b010, 32'h0, 1'b0, 32'hBEADF00D, 1'b0);

    // Back-pressure: a store held on req_valid during WAIT/RESP must be ignored.
    applyStimulus("sw_8", 1'b1, 32'h0001_0008, 3'b010, 32'h11111111, 1'b0, 32'h0, 1'b0);
    reqValid  = 1'b1;
    reqWe     = 1'b0;
    reqAddr   = 32'h0001_0000;
    reqFunct3 = 3'b010;
    rspReady  = 1'b0;
    @(posedge clk); #1;
    reqWe    = 1'b1;
    reqAddr  = 32'h0001_0008;
    reqWdata = 32'h22222222;
    @(posedge clk); #1;
    checkOutput("hold/valid0", 32'(rspValid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold/valid%0d", i + 1), 32'(rspValid), 32'd1);
      checkOutput($sformatf("hold/rdata%0d", i + 1), rspRdata, 32'hDEAD12EF);
      checkOutput($sformatf("hold/ready%0d", i + 1), 32'(reqReady), 32'd0);
    end
    reqValid = 1'b0;
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    checkOutput("hold/retired", 32'(rspValid), 32'd0);
    checkOutput("hold/idle", 32'(reqReady), 32'd1);
    applyStimulus("lw_8", 1'b0, 32'h0001_0008, 3'b010, 32'h0, 1'b0, 32'h11111111, 1'b0);

    // Reset while the store to 0x10004 is still waiting for its commit edge.
    applyStimulus("sw_4", 1'b1, 32'h0001_0004, 3'b010, 32'h55AA55AA, 1'b0, 32'h0, 1'b0);
    reqValid  = 1'b1;
    reqWe     = 1'b1;
    reqAddr   = 32'h0001_0004;
    reqFunct3 = 3'b010;
    reqWdata  = 32'h00000001;
    @(posedge clk); #1;
    reqValid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst/req_ready", 32'(reqReady), 32'd0);
    checkOutput("midrst/rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("midrst/rdata", rspRdata, 32'h0);
    checkOutput("midrst/err", 32'(rspErr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus("lw_4", 1'b0, 32'h0001_0004, 3'b010, 32'h0, 1'b0, 32'h55AA55AA, 1'b0);
    applyStimulus("lw_0", 1'b0, 32'h0001_0000, 3'b010, 32'h0, 1'b0, 32'hDEAD12EF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
